// File: rtl/weight_load_ctrl_pkg.sv
// weight_load_ctrl_pkg: shared sizes and state encoding for the weight-bank loader.
//   NUM_WEIGHTS : weights per load (bank depth)
//   DATA_W      : weight / stream byte width
//   ADDR_W      : bank address width, 2**ADDR_W >= NUM_WEIGHTS
//   state_t     : loader FSM states
package weight_load_ctrl_pkg;
    localparam int NUM_WEIGHTS = 30;
    localparam int DATA_W      = 8;
    localparam int ADDR_W      = 5;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/weight_load_ctrl_if.sv
// weight_load_ctrl_if: byte stream in and bank write strobes out of the loader.
//   in_valid/in_data/in_ready : valid/ready byte stream (weights, then checksum)
//   wr_data/wr_addr/wr_en     : bank dataIn/address/write
//   slave  : loader side
//   master : stream source and bank side
interface weight_load_ctrl_if;
    import weight_load_ctrl_pkg::*;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en;
    modport master (output in_valid, in_data, input in_ready, wr_data, wr_addr, wr_en);
    modport slave  (input in_valid, in_data, output in_ready, wr_data, wr_addr, wr_en);
endinterface

// File: rtl/weight_load_ctrl.sv
// weight_load_ctrl: loads the weight bank from a byte stream and verifies a trailing checksum.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begins a load when idle
//   abort      : cancels a load in progress
//   bus        : byte stream in, bank write strobes out (slave modport)
//   busy       : load or checksum phase in progress
//   done       : one-cycle pulse when a load completes
//   error      : sticky checksum mismatch, cleared by the next start
module weight_load_ctrl
    import weight_load_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    weight_load_ctrl_if.slave   bus,
    output logic                busy,
    output logic                done,
    output logic                error
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] sum;
    logic              rdy;
    logic              take;
    // a byte arriving together with abort is dropped
    assign take = bus.in_valid & rdy & ~abort;
    assign bus.in_ready = rdy;
    always_comb begin
        state_nxt = state;
        rdy       = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: state_nxt = start ? LOAD : IDLE;
            LOAD: begin
                rdy       = 1'b1;
                busy      = 1'b1;
                state_nxt = abort ? IDLE
                          : (take && count == ADDR_W'(NUM_WEIGHTS - 1)) ? CHECK : LOAD;
            end
            CHECK: begin
                rdy       = 1'b1;
                busy      = 1'b1;
                state_nxt = abort ? IDLE : take ? DONE : CHECK;
            end
            default: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    // write strobes are registered: one cycle of latency from accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            sum         <= '0;
            error       <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_data <= '0;
            bus.wr_addr <= '0;
        end else begin
            bus.wr_en <= take && state == LOAD;
            if (state == IDLE && start) begin
                count <= '0;
                sum   <= '0;
                error <= 1'b0;
            end
            if (take && state == LOAD) begin
                bus.wr_data <= bus.in_data;
                bus.wr_addr <= count;
                count       <= count + 1'b1;
                sum         <= sum + bus.in_data;
            end
            if (take && state == CHECK && bus.in_data != sum)
                error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_weight_load_ctrl.sv
// tb_weight_load_ctrl: randomized self-checking bench for weight_load_ctrl.
module tb_weight_load_ctrl;
    import weight_load_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, error;

    weight_load_ctrl_if bus();

    weight_load_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .error (error)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0]        stim [NUM_WEIGHTS];
    logic [DATA_W-1:0]        bank [2**ADDR_W];
    logic [ADDR_W+DATA_W-1:0] obs_q [$];
    int                       done_cnt = 0;
    logic                     hi_write = 1'b0;
    int                       n_tests = 0;
    int                       n_fail = 0;

    // bank model and write/done observer, sampled away from the rising edge
    always @(negedge clk) begin
        if (bus.wr_en) begin
            obs_q.push_back({bus.wr_addr, bus.wr_data});
            bank[bus.wr_addr] = bus.wr_data;
            if (int'(bus.wr_addr) >= NUM_WEIGHTS) hi_write = 1'b1;
        end
        if (done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] model_sum();
        int s = 0;
        for (int i = 0; i < NUM_WEIGHTS; i++) s += int'(stim[i]);
        return DATA_W'(s % 256);
    endfunction

    // mismatches between observed writes since base and the first n expected writes
    function automatic int bad_writes(int base, int n);
        int bad = 0;
        if (obs_q.size() - base != n) bad++;
        for (int i = 0; i < n; i++)
            if (base + i >= obs_q.size() || obs_q[base + i] !== {ADDR_W'(i), stim[i]}) bad++;
        return bad;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [DATA_W-1:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = b;
        t = 0;
        while (!bus.in_ready && t < 16) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready: got %b, expected 1", bus.in_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            start = 1'b0;
            abort = 1'b0;
        end
    endtask

    // mode 0: back-to-back, 1: in_valid low every other cycle, 2: random gaps
    task automatic drive_load(input logic [DATA_W-1:0] chk, input int mode,
                              input bit start_mid, input bit start_done);
        pulse_start();
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            if (start_mid && i == NUM_WEIGHTS / 2) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            send(stim[i], mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 2)));
        end
        send(chk, mode == 0 ? 0 : 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        start = start_done;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_tests++;
        if ({bus.in_ready, bus.wr_en, bus.wr_data, bus.wr_addr, busy, done, error} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected all zero",
                     {bus.in_ready, bus.wr_en, bus.wr_data, bus.wr_addr, busy, done, error});
        end
        rst_n = 1'b1;
        idle(3);
        n_tests++;
        if ({bus.in_ready, bus.wr_en, busy, done, error} !== '0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %b, expected 00000",
                     {bus.in_ready, bus.wr_en, busy, done, error});
        end
    endtask

    task automatic test_ramp();
        int base = obs_q.size();
        int d0 = done_cnt;
        int bw, bb;
        for (int i = 0; i < NUM_WEIGHTS; i++) stim[i] = DATA_W'(i);
        drive_load(8'hB3, 0, 1'b0, 1'b0);
        bw = bad_writes(base, NUM_WEIGHTS);
        n_tests++;
        if (bw != 0) begin
            n_fail++;
            $display("FAIL ramp_writes: got %0d bad of %0d writes, expected 0", bw, obs_q.size() - base);
        end
        n_tests++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL ramp_done: got %0d pulses, expected 1", done_cnt - d0);
        end
        n_tests++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL ramp_error: got %b, expected 0", error);
        end
        bb = 0;
        for (int i = 0; i < NUM_WEIGHTS; i++) if (bank[i] !== DATA_W'(i)) bb++;
        n_tests++;
        if (bb != 0) begin
            n_fail++;
            $display("FAIL ramp_bank: got %0d wrong entries, expected 0", bb);
        end
    endtask

    task automatic test_bad_checksum();
        int d0 = done_cnt;
        for (int i = 0; i < NUM_WEIGHTS; i++) stim[i] = DATA_W'(i);
        drive_load(8'h00, 0, 1'b0, 1'b0);
        n_tests++;
        if (done_cnt - d0 != 1 || error !== (model_sum() != 8'h00)) begin
            n_fail++;
            $display("FAIL badchk_flag: got done=%0d error=%b, expected done=1 error=1",
                     done_cnt - d0, error);
        end
        idle(2);
        n_tests++;
        if (error !== 1'b1) begin
            n_fail++;
            $display("FAIL badchk_sticky: got %b, expected 1", error);
        end
        pulse_start();
        n_tests++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL badchk_clear: got error=%b busy=%b, expected error=0 busy=1", error, busy);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL badchk_abort_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_gaps();
        int base = obs_q.size();
        int d0 = done_cnt;
        int bw;
        for (int i = 0; i < NUM_WEIGHTS; i++) stim[i] = 8'hFF;
        drive_load(8'hE2, 1, 1'b0, 1'b0);
        bw = bad_writes(base, NUM_WEIGHTS);
        n_tests++;
        if (bw != 0) begin
            n_fail++;
            $display("FAIL gaps_writes: got %0d bad of %0d writes, expected 0", bw, obs_q.size() - base);
        end
        n_tests++;
        if (done_cnt - d0 != 1 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_status: got done=%0d error=%b, expected done=1 error=0", done_cnt - d0, error);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int base = obs_q.size();
            int d0 = done_cnt;
            int bw;
            logic [DATA_W-1:0] chk;
            bit sm = 1'($urandom_range(0, 1));
            bit sd = 1'($urandom_range(0, 1));
            for (int i = 0; i < NUM_WEIGHTS; i++) stim[i] = DATA_W'($urandom);
            chk = model_sum() ^ ($urandom_range(0, 1) != 0 ? DATA_W'($urandom_range(1, 255)) : 8'h00);
            drive_load(chk, 2, sm, sd);
            bw = bad_writes(base, NUM_WEIGHTS);
            n_tests++;
            if (bw != 0) begin
                n_fail++;
                $display("FAIL rand%0d_writes: got %0d bad, expected 0", it, bw);
            end
            n_tests++;
            if (done_cnt - d0 != 1 || error !== (chk != model_sum()) || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_status: got done=%0d error=%b busy=%b, expected done=1 error=%b busy=0",
                         it, done_cnt - d0, error, busy, chk != model_sum());
            end
        end
    endtask

    task automatic test_abort();
        int base = obs_q.size();
        int d0 = done_cnt;
        int bw;
        for (int i = 0; i < NUM_WEIGHTS; i++) stim[i] = DATA_W'($urandom);
        pulse_start();
        for (int i = 0; i < 10; i++) send(stim[i], int'($urandom_range(0, 1)));
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h5A;
        abort = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        abort = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b in_ready=%b, expected 0 0", busy, bus.in_ready);
        end
        idle(3);
        bw = bad_writes(base, 10);
        n_tests++;
        if (bw != 0 || done_cnt != d0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_effect: got bad=%0d done=%0d error=%b, expected 0 0 0", bw, done_cnt - d0, error);
        end
        base = obs_q.size();
        drive_load(model_sum(), 2, 1'b0, 1'b0);
        bw = bad_writes(base, NUM_WEIGHTS);
        n_tests++;
        if (bw != 0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reload: got bad=%0d error=%b, expected 0 0", bw, error);
        end
    endtask

    task automatic test_reset_mid();
        int base = obs_q.size();
        int bw;
        for (int i = 0; i < NUM_WEIGHTS; i++) stim[i] = DATA_W'($urandom);
        pulse_start();
        for (int i = 0; i < 5; i++) send(stim[i], 0);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.in_ready, bus.wr_en, bus.wr_data, bus.wr_addr, busy, done, error} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %b, expected all zero",
                     {bus.in_ready, bus.wr_en, bus.wr_data, bus.wr_addr, busy, done, error});
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);
        bw = bad_writes(base, 4);
        n_tests++;
        if (bw != 0) begin
            n_fail++;
            $display("FAIL rstmid_writes: got %0d bad of %0d writes, expected 0 of 4", bw, obs_q.size() - base);
        end
        base = obs_q.size();
        drive_load(model_sum(), 0, 1'b0, 1'b0);
        bw = bad_writes(base, NUM_WEIGHTS);
        n_tests++;
        if (bw != 0 || error !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_reload: got bad=%0d error=%b, expected 0 0", bw, error);
        end
    endtask

    task automatic test_start_ignored();
        int base = obs_q.size();
        int d0 = done_cnt;
        int bw;
        for (int i = 0; i < NUM_WEIGHTS; i++) stim[i] = DATA_W'($urandom);
        drive_load(model_sum(), 0, 1'b1, 1'b1);
        bw = bad_writes(base, NUM_WEIGHTS);
        n_tests++;
        if (bw != 0) begin
            n_fail++;
            $display("FAIL startign_writes: got %0d bad, expected 0", bw);
        end
        n_tests++;
        if (busy !== 1'b0 || error !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL startign_status: got busy=%b error=%b done=%0d, expected 0 0 1",
                     busy, error, done_cnt - d0);
        end
        n_tests++;
        if (hi_write !== 1'b0) begin
            n_fail++;
            $display("FAIL addr_range: got write above %0d, expected none", NUM_WEIGHTS - 1);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        test_reset();
        test_ramp();
        test_bad_checksum();
        test_gaps();
        test_random();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
